// File: rtl/ps2_host_port.sv
// Host-side PS/2 link controller: conditions PS2C/PS2D, receives device frames and sends one
// command byte using the inhibit / request-to-send handshake with a device ACK check.
module ps2_host_port #(
    parameter int CLK_PER_US = 50,
    parameter int INHIBIT_US = 100,
    parameter int RTS_US     = 5,
    parameter int TIMEOUT_US = 2000,
    parameter int FILTER_CYC = 8
) (
    input  logic       qzt_clk,
    input  logic       reset,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_drive_low,
    output logic       ps2d_drive_low,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err
);
    localparam int MAX_US = (TIMEOUT_US > INHIBIT_US) ? TIMEOUT_US : INHIBIT_US;
    localparam int US_W   = $clog2(MAX_US + 2);
    localparam int PRE_W  = $clog2(CLK_PER_US + 1);
    localparam int FLT_W  = $clog2(FILTER_CYC + 1);

    localparam logic [US_W-1:0]  INHIBIT_LIM = US_W'(INHIBIT_US);
    localparam logic [US_W-1:0]  RTS_LIM     = US_W'(RTS_US);
    localparam logic [US_W-1:0]  TMO_LIM     = US_W'(TIMEOUT_US);
    localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(CLK_PER_US - 1);
    localparam logic [FLT_W-1:0] FLT_LAST    = FLT_W'(FILTER_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, RX_BITS, RX_DONE, TX_INHIBIT, TX_RTS, TX_BITS, TX_ACK, TX_END
    } state_t;

    logic             c_meta_q, c_sync_q, d_meta_q, d_sync_q;
    logic             c_filt_q, c_filt_d, c_filt_prev_q;
    logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
    logic             fall, rise;

    state_t           state_q;
    logic [PRE_W-1:0] pre_q;
    logic [US_W-1:0]  us_q;
    logic [3:0]       bit_q;
    logic [9:0]       rx_sh_q;
    logic [9:0]       tx_sh_q;
    logic             ack_ok_q, err_q;
    logic             c_low_q, d_low_q, tx_busy_q, tx_done_q, tx_err_q;
    logic [7:0]       rx_data_q;
    logic             rx_valid_q, rx_err_q;

    // A PS2C level change is accepted only after FILTER_CYC identical synchronized samples.
    always_comb begin
        flt_cnt_d = '0;
        c_filt_d  = c_filt_q;
        if (c_sync_q != c_filt_q) begin
            if (flt_cnt_q == FLT_LAST) c_filt_d = c_sync_q;
            else                       flt_cnt_d = flt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            c_meta_q      <= 1'b1;
            c_sync_q      <= 1'b1;
            d_meta_q      <= 1'b1;
            d_sync_q      <= 1'b1;
            c_filt_q      <= 1'b1;
            c_filt_prev_q <= 1'b1;
            flt_cnt_q     <= '0;
        end else begin
            c_meta_q      <= ps2c_in;
            c_sync_q      <= c_meta_q;
            d_meta_q      <= ps2d_in;
            d_sync_q      <= d_meta_q;
            c_filt_q      <= c_filt_d;
            c_filt_prev_q <= c_filt_q;
            flt_cnt_q     <= flt_cnt_d;
        end
    end

    assign fall = c_filt_prev_q & ~c_filt_q;
    assign rise = ~c_filt_prev_q & c_filt_q;

    // Timer restarts on every fall and on every state entry; later assignments override.
    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            us_q       <= '0;
            bit_q      <= '0;
            rx_sh_q    <= '0;
            tx_sh_q    <= '0;
            ack_ok_q   <= 1'b0;
            err_q      <= 1'b0;
            c_low_q    <= 1'b0;
            d_low_q    <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_err_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_err_q   <= 1'b0;
            if (pre_q == PRE_LAST) begin
                pre_q <= '0;
                if (us_q != '1) us_q <= us_q + 1'b1;
            end else begin
                pre_q <= pre_q + 1'b1;
            end
            if (fall) begin
                pre_q <= '0;
                us_q  <= '0;
            end
            case (state_q)
                IDLE: begin
                    c_low_q <= 1'b0;
                    d_low_q <= 1'b0;
                    if (fall && !d_sync_q) begin
                        state_q <= RX_BITS;
                        bit_q   <= '0;
                        pre_q   <= '0;
                        us_q    <= '0;
                    end else if (tx_start) begin
                        state_q   <= TX_INHIBIT;
                        tx_sh_q   <= {1'b1, ~^tx_data, tx_data};
                        tx_busy_q <= 1'b1;
                        c_low_q   <= 1'b1;
                        err_q     <= 1'b0;
                        pre_q     <= '0;
                        us_q      <= '0;
                    end
                end
                RX_BITS: begin
                    if (fall) begin
                        rx_sh_q <= {d_sync_q, rx_sh_q[9:1]};
                        if (bit_q != 4'hF) bit_q <= bit_q + 1'b1;
                        if (bit_q == 4'd9) state_q <= RX_DONE;
                    end else if (us_q >= TMO_LIM) begin
                        state_q <= IDLE;
                        pre_q   <= '0;
                        us_q    <= '0;
                    end
                end
                RX_DONE: begin
                    rx_data_q  <= rx_sh_q[7:0];
                    rx_valid_q <= 1'b1;
                    rx_err_q   <= ~(^rx_sh_q[8:0]) | ~rx_sh_q[9];
                    state_q    <= IDLE;
                    pre_q      <= '0;
                    us_q       <= '0;
                end
                TX_INHIBIT: begin
                    if (us_q >= INHIBIT_LIM) begin
                        state_q <= TX_RTS;
                        d_low_q <= 1'b1;
                        pre_q   <= '0;
                        us_q    <= '0;
                    end
                end
                TX_RTS: begin
                    if (us_q >= RTS_LIM) begin
                        state_q <= TX_BITS;
                        c_low_q <= 1'b0;
                        bit_q   <= '0;
                        pre_q   <= '0;
                        us_q    <= '0;
                    end
                end
                TX_BITS: begin
                    // Start bit is already on the line from RTS; each fall presents the next bit.
                    if (fall) begin
                        d_low_q <= ~tx_sh_q[bit_q];
                        if (bit_q != 4'hF) bit_q <= bit_q + 1'b1;
                        if (bit_q == 4'd9) begin
                            state_q <= TX_ACK;
                            bit_q   <= '0;
                        end
                    end else if (us_q >= TMO_LIM) begin
                        state_q <= TX_END;
                        err_q   <= 1'b1;
                        d_low_q <= 1'b0;
                        pre_q   <= '0;
                        us_q    <= '0;
                    end
                end
                TX_ACK: begin
                    if (bit_q == 4'd0 && fall) begin
                        ack_ok_q <= ~d_sync_q;
                        bit_q    <= 4'd1;
                    end else if (bit_q == 4'd1 && rise) begin
                        state_q <= TX_END;
                        err_q   <= ~ack_ok_q;
                        pre_q   <= '0;
                        us_q    <= '0;
                    end else if (us_q >= TMO_LIM) begin
                        state_q <= TX_END;
                        err_q   <= 1'b1;
                        pre_q   <= '0;
                        us_q    <= '0;
                    end
                end
                TX_END: begin
                    tx_done_q <= 1'b1;
                    tx_err_q  <= err_q;
                    tx_busy_q <= 1'b0;
                    c_low_q   <= 1'b0;
                    d_low_q   <= 1'b0;
                    state_q   <= IDLE;
                    pre_q     <= '0;
                    us_q      <= '0;
                end
            endcase
        end
    end

    assign ps2c_drive_low = c_low_q;
    assign ps2d_drive_low = d_low_q;
    assign tx_busy        = tx_busy_q;
    assign tx_done        = tx_done_q;
    assign tx_err         = tx_err_q;
    assign rx_data        = rx_data_q;
    assign rx_valid       = rx_valid_q;
    assign rx_err         = rx_err_q;

endmodule

// File: tb/tb_ps2_host_port.sv
// Directed bench for ps2_host_port: open-drain line model plus a simple PS/2 device driven
// from one linear stimulus sequence, running the controller at 4 clocks per microsecond.
module tb_ps2_host_port;
    localparam int CPU  = 4;
    localparam int HALF = 40 * CPU;
    localparam int QTR  = 10 * CPU;
    localparam int TMO_CYC = 2000 * CPU;

    logic       qzt_clk, reset;
    logic       ps2c_in, ps2d_in;
    logic       ps2c_drive_low, ps2d_drive_low;
    logic [7:0] tx_data;
    logic       tx_start, tx_busy, tx_done, tx_err;
    logic [7:0] rx_data;
    logic       rx_valid, rx_err;
    logic       dev_c_low, dev_d_low;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         rx_cnt = 0;
    int         done_cnt = 0;
    logic [7:0] rx_last_data = '0;
    logic       rx_last_err = 1'b0;
    logic       last_tx_err = 1'b0;

    ps2_host_port #(
        .CLK_PER_US(CPU), .INHIBIT_US(100), .RTS_US(5), .TIMEOUT_US(2000), .FILTER_CYC(8)
    ) dut (
        .qzt_clk(qzt_clk), .reset(reset), .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
        .ps2c_drive_low(ps2c_drive_low), .ps2d_drive_low(ps2d_drive_low),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
        .tx_err(tx_err), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err)
    );

    assign ps2c_in = ~(ps2c_drive_low | dev_c_low);
    assign ps2d_in = ~(ps2d_drive_low | dev_d_low);

    initial qzt_clk = 1'b0;
    always #5 qzt_clk = ~qzt_clk;

    always @(negedge qzt_clk) begin
        if (rx_valid === 1'b1) begin
            rx_cnt++;
            rx_last_data = rx_data;
            rx_last_err  = rx_err;
        end
        if (tx_done === 1'b1) begin
            done_cnt++;
            last_tx_err = tx_err;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Device-to-host frame: start, data LSB first, parity, stop; nclk limits the clocks sent.
    task automatic dev_send(input logic [7:0] data, input logic par, input int nclk);
        logic [10:0] fr;
        fr = {1'b1, par, data, 1'b0};
        for (int i = 0; i < nclk; i++) begin
            dev_d_low = ~fr[i];
            repeat (QTR) @(negedge qzt_clk);
            dev_c_low = 1'b1;
            repeat (HALF) @(negedge qzt_clk);
            dev_c_low = 1'b0;
            repeat (HALF - QTR) @(negedge qzt_clk);
        end
        dev_d_low = 1'b0;
    endtask

    // Device side of a host-to-device transfer: reads 10 bits late in each low phase, then ACKs.
    task automatic dev_recv(output logic [9:0] bits, input logic ack);
        bits = '0;
        for (int i = 0; i < 10; i++) begin
            repeat (QTR) @(negedge qzt_clk);
            dev_c_low = 1'b1;
            repeat (HALF) @(negedge qzt_clk);
            bits[i] = ps2d_in;
            dev_c_low = 1'b0;
            repeat (HALF - QTR) @(negedge qzt_clk);
        end
        repeat (QTR) @(negedge qzt_clk);
        dev_d_low = ack;
        dev_c_low = 1'b1;
        repeat (HALF) @(negedge qzt_clk);
        dev_c_low = 1'b0;
        repeat (QTR) @(negedge qzt_clk);
        dev_d_low = 1'b0;
    endtask

    initial begin
        logic [9:0] got;
        int n, inh, cyc;
        reset = 1'b1; tx_start = 1'b0; tx_data = '0; dev_c_low = 1'b0; dev_d_low = 1'b0;
        repeat (5) @(negedge qzt_clk);
        check("rst_c_low", ps2c_drive_low, 0);
        check("rst_d_low", ps2d_drive_low, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_tx_err", tx_err, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_err", rx_err, 0);
        reset = 1'b0;
        repeat (50) @(negedge qzt_clk);

        dev_send(8'hFA, 1'b1, 11);
        repeat (20) @(negedge qzt_clk);
        check("rxFA_cnt", rx_cnt, 1);
        check("rxFA_data", rx_last_data, 8'hFA);
        check("rxFA_err", rx_last_err, 0);

        dev_send(8'h08, 1'b1, 11);
        repeat (20) @(negedge qzt_clk);
        check("rx08_cnt", rx_cnt, 2);
        check("rx08_data", rx_last_data, 8'h08);
        check("rx08_err", rx_last_err, 1);

        dev_send(8'h01, 1'b0, 11);
        repeat (20) @(negedge qzt_clk);
        check("rx01_cnt", rx_cnt, 3);
        check("rx01_data", rx_last_data, 8'h01);
        check("rx01_err", rx_last_err, 0);

        tx_data = 8'hF4; tx_start = 1'b1;
        @(negedge qzt_clk);
        tx_start = 1'b0;
        check("txF4_busy", tx_busy, 1);
        n = 0; inh = 0;
        while (ps2d_drive_low !== 1'b1 && n < 4000) begin
            if (ps2c_drive_low === 1'b1) inh++;
            @(negedge qzt_clk);
            n++;
        end
        check("txF4_rts_c_low", ps2c_drive_low, 1);
        n_cmp++;
        assert (inh >= 100 * CPU) else begin
            n_fail++;
            $error("FAIL txF4_inhibit_len: observed %0d cycles required >= %0d", inh, 100 * CPU);
        end
        n = 0;
        while (ps2c_drive_low !== 1'b0 && n < 400) begin
            @(negedge qzt_clk);
            n++;
        end
        check("txF4_c_release", ps2c_drive_low, 0);
        check("txF4_start_low", ps2d_drive_low, 1);
        dev_recv(got, 1'b1);
        n = 0;
        while (done_cnt < 1 && n < 2000) begin
            @(negedge qzt_clk);
            n++;
        end
        check("txF4_bits", got, 10'h2F4);
        check("txF4_done_cnt", done_cnt, 1);
        check("txF4_err", last_tx_err, 0);
        check("txF4_busy_end", tx_busy, 0);
        check("txF4_lines", {ps2c_drive_low, ps2d_drive_low}, 0);
        check("txF4_no_rx", rx_cnt, 3);

        tx_data = 8'hFF; tx_start = 1'b1;
        @(negedge qzt_clk);
        tx_start = 1'b0;
        n = 0;
        while (ps2c_drive_low !== 1'b0 && n < 1000) begin
            @(negedge qzt_clk);
            n++;
        end
        check("txFF_c_release", ps2c_drive_low, 0);
        cyc = 0;
        while (tx_done !== 1'b1 && cyc < TMO_CYC + 1000) begin
            @(negedge qzt_clk);
            cyc++;
        end
        n_cmp++;
        assert (cyc >= TMO_CYC - CPU && cyc <= TMO_CYC + CPU) else begin
            n_fail++;
            $error("FAIL txFF_timeout: observed %0d cycles required %0d +- %0d", cyc, TMO_CYC, CPU);
        end
        check("txFF_err", tx_err, 1);
        check("txFF_lines", {ps2c_drive_low, ps2d_drive_low}, 0);
        @(negedge qzt_clk);
        check("txFF_busy_end", tx_busy, 0);

        dev_send(8'hFA, 1'b1, 5);
        repeat (TMO_CYC + 400) @(negedge qzt_clk);
        check("rx_abort_cnt", rx_cnt, 3);
        dev_send(8'hFA, 1'b1, 11);
        repeat (20) @(negedge qzt_clk);
        check("rx_after_abort_cnt", rx_cnt, 4);
        check("rx_after_abort_data", rx_last_data, 8'hFA);
        check("rx_after_abort_err", rx_last_err, 0);

        tx_data = 8'h55; tx_start = 1'b1;
        @(negedge qzt_clk);
        tx_start = 1'b0;
        n = 0;
        while (ps2c_drive_low !== 1'b0 && n < 1000) begin
            @(negedge qzt_clk);
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            repeat (QTR) @(negedge qzt_clk);
            dev_c_low = 1'b1;
            repeat (HALF) @(negedge qzt_clk);
            dev_c_low = 1'b0;
            repeat (HALF - QTR) @(negedge qzt_clk);
        end
        dev_c_low = 1'b1;
        repeat (QTR) @(negedge qzt_clk);
        check("mid_busy", tx_busy, 1);
        reset = 1'b1;
        @(negedge qzt_clk);
        reset = 1'b0;
        check("mid_rst_lines", {ps2c_drive_low, ps2d_drive_low}, 0);
        check("mid_rst_busy", tx_busy, 0);
        dev_c_low = 1'b0;
        repeat (400) @(negedge qzt_clk);
        check("mid_rst_no_done", done_cnt, 2);
        check("mid_rst_no_rx", rx_cnt, 4);

        tx_data = 8'h00; tx_start = 1'b1;
        @(negedge qzt_clk);
        tx_start = 1'b0;
        check("retx_busy", tx_busy, 1);
        repeat (5) @(negedge qzt_clk);
        check("retx_c_low", ps2c_drive_low, 1);
        n = 0;
        while (tx_done !== 1'b1 && n < TMO_CYC + 2000) begin
            @(negedge qzt_clk);
            n++;
        end
        check("retx_err", tx_err, 1);
        @(negedge qzt_clk);
        check("retx_done_cnt", done_cnt, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
